// File: rtl/ysyx_23060124_exu_mdu_if.sv
// Handshake bundle between the IDU-side issuer (master) and the execute unit (slave).
interface ysyx_23060124_exu_mdu_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
);
    logic            i_valid;
    logic            o_ready;
    logic [OPW-1:0]  i_opt;
    logic [XLEN-1:0] i_src1;
    logic [XLEN-1:0] i_src2;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_res;
    logic            o_zero;
    logic            o_busy;

    modport master (
        output i_valid, i_opt, i_src1, i_src2, i_flush, i_ready,
        input  o_ready, o_valid, o_res, o_zero, o_busy
    );

    modport slave (
        input  i_valid, i_opt, i_src1, i_src2, i_flush, i_ready,
        output o_ready, o_valid, o_res, o_zero, o_busy
    );
endinterface

// File: rtl/ysyx_23060124_exu_mdu.sv
// Execute unit: 1-cycle ALU/branch ops plus iterative shift-add multiply and restoring divide.
// Define YSYX_23060124_EXU_FAST_MUL_EN to make MUL* single-cycle via a combinational multiplier.
module ysyx_23060124_exu_mdu #(
    parameter int XLEN = 32,
    parameter int OPW  = 5,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic clk,
    input  logic i_rst,
    ysyx_23060124_exu_mdu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(0),  OP_SUB    = OPW'(1),  OP_SLL  = OPW'(2);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(3),  OP_SLTU   = OPW'(4),  OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6),  OP_SRA    = OPW'(7),  OP_OR   = OPW'(8);
    localparam logic [OPW-1:0] OP_AND  = OPW'(9),  OP_MUL    = OPW'(10), OP_MULH = OPW'(11);
    localparam logic [OPW-1:0] OP_MULHSU = OPW'(12), OP_MULHU = OPW'(13), OP_DIV = OPW'(14);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(15), OP_REM    = OPW'(16), OP_REMU = OPW'(17);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(18), OP_BNE    = OPW'(19), OP_BLT  = OPW'(20);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(21), OP_BLTU   = OPW'(22), OP_BGEU = OPW'(23);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   res, b_q;
    logic [2*XLEN-1:0] acc;
    logic [OPW-1:0]    op_q;
    logic              neg_q;
    logic [CNTW-1:0]   cnt;

    logic [OPW-1:0]  op;
    logic [XLEN-1:0] a, b, mag1, mag2, imm_res;
    logic [SHW-1:0]  sh;
    logic take, is_mul, is_div, is_rem, sgn1, sgn2, s1_neg, s2_neg, div_zero, div_ovf, go_busy;

    assign op = bus.i_opt;
    assign a  = bus.i_src1;
    assign b  = bus.i_src2;
    assign sh = b[SHW-1:0];

    // Flush wins over a new request, so ready drops while it is asserted.
    assign bus.o_ready = !bus.i_flush && (state == IDLE || (state == DONE && bus.i_ready));
    assign take        = bus.i_valid && bus.o_ready;
    assign bus.o_valid = (state == DONE);
    assign bus.o_busy  = (state == BUSY);
    assign bus.o_res   = res;
    assign bus.o_zero  = (res == '0);

    assign is_mul   = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign is_rem   = op inside {OP_REM, OP_REMU};
    assign sgn1     = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign sgn2     = op inside {OP_MULH, OP_DIV, OP_REM};
    assign s1_neg   = sgn1 && a[XLEN-1];
    assign s2_neg   = sgn2 && b[XLEN-1];
    assign mag1     = s1_neg ? -a : a;
    assign mag2     = s2_neg ? -b : b;
    assign div_zero = is_div && (b == '0);
    assign div_ovf  = (op == OP_DIV || op == OP_REM) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef YSYX_23060124_EXU_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_f;
    // Truncated product of sign/zero-extended operands is exact modulo 2^(2*XLEN).
    assign prod_f  = {{XLEN{s1_neg}}, a} * {{XLEN{sgn2 && b[XLEN-1]}}, b};
    assign go_busy = is_div && !div_zero && !div_ovf;
`else
    assign go_busy = is_mul || (is_div && !div_zero && !div_ovf);
`endif

    always_comb begin
        imm_res = '0;
        case (op)
            OP_ADD:  imm_res = a + b;
            OP_SUB:  imm_res = a - b;
            OP_SLL:  imm_res = a << sh;
            OP_SLT:  imm_res = XLEN'($signed(a) < $signed(b));
            OP_SLTU: imm_res = XLEN'(a < b);
            OP_XOR:  imm_res = a ^ b;
            OP_SRL:  imm_res = a >> sh;
            OP_SRA:  imm_res = $signed(a) >>> sh;
            OP_OR:   imm_res = a | b;
            OP_AND:  imm_res = a & b;
`ifdef YSYX_23060124_EXU_FAST_MUL_EN
            OP_MUL:  imm_res = prod_f[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: imm_res = prod_f[2*XLEN-1:XLEN];
`endif
            OP_DIV, OP_DIVU: imm_res = div_zero ? '1 : a;
            OP_REM, OP_REMU: imm_res = div_zero ? a : '0;
            OP_BEQ:  imm_res = XLEN'(a == b);
            OP_BNE:  imm_res = XLEN'(a != b);
            OP_BLT:  imm_res = XLEN'($signed(a) < $signed(b));
            OP_BGE:  imm_res = XLEN'($signed(a) >= $signed(b));
            OP_BLTU: imm_res = XLEN'(a < b);
            OP_BGEU: imm_res = XLEN'(a >= b);
            default: imm_res = '0;
        endcase
    end

    // acc = {hi, lo}: product accumulator / multiplier for MUL*, remainder / quotient for DIV*.
    logic [XLEN:0]     add_s, rem_sh, diff;
    logic [2*XLEN-1:0] acc_nx, prod;
    logic [XLEN-1:0]   q_nx, r_nx, fin;

    assign add_s  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    assign rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_q};

    always_comb begin
        if (op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
            acc_nx = {add_s, acc[XLEN-1:1]};
        else if (diff[XLEN])
            acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    assign prod = neg_q ? -acc_nx : acc_nx;
    assign q_nx = acc_nx[XLEN-1:0];
    assign r_nx = acc_nx[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            OP_MUL:          fin = prod[XLEN-1:0];
            OP_DIV, OP_DIVU: fin = neg_q ? -q_nx : q_nx;
            OP_REM, OP_REMU: fin = neg_q ? -r_nx : r_nx;
            default:         fin = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            res   <= '0;
            cnt   <= '0;
            acc   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else if (bus.i_flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (take) begin
                        op_q <= op;
                        if (go_busy) begin
                            acc   <= {{XLEN{1'b0}}, mag1};
                            b_q   <= mag2;
                            neg_q <= is_rem ? s1_neg : (s1_neg ^ s2_neg);
                            cnt   <= CNTW'(XLEN);
                            state <= BUSY;
                        end else begin
                            res   <= imm_res;
                            state <= DONE;
                        end
                    end else if (state == DONE && bus.i_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    acc <= acc_nx;
                    cnt <= cnt - CNTW'(1);
                    if (cnt == CNTW'(1)) begin
                        res   <= fin;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060124_exu_mdu.sv
// Scoreboard bench for ysyx_23060124_exu_mdu (XLEN=32); expected results queued at issue, checked on output.
module tb_ysyx_23060124_exu_mdu;
    localparam logic [4:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR_ = 5, SRL = 6, SRA = 7;
    localparam logic [4:0] MUL = 10, MULH = 11, MULHSU = 12, MULHU = 13, DIV = 14, DIVU = 15, REM = 16, REMU = 17;
    localparam logic [4:0] BEQ = 18, BNE = 19, BLT = 20, BGE = 21, BLTU = 22, BGEU = 23;
`ifdef YSYX_23060124_EXU_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif

    logic clk = 0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    string       tq[$];
    logic [31:0] vq[$];

    ysyx_23060124_exu_mdu_if #(.XLEN(32), .OPW(5)) bus ();
    ysyx_23060124_exu_mdu #(.XLEN(32), .OPW(5)) dut (.clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        string       t;
        logic [31:0] v;
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (vq.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                t = tq.pop_front();
                v = vq.pop_front();
                chk(t, bus.o_res, v);
                chk({t, "_zero"}, bus.o_zero, v == 0);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input string t, input bit push, output int waits);
        bus.i_valid = 1; bus.i_opt = op; bus.i_src1 = a; bus.i_src2 = b;
        waits = 0;
        @(negedge clk);
        while (!bus.o_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.o_ready) chk({t, "_accept_timeout"}, 0, 1);
        else if (push) begin
            tq.push_back(t);
            vq.push_back(e);
        end
        @(posedge clk); #1;
        bus.i_valid = 0;
    endtask

    task automatic issue_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] e, input string t, input int exp_lat);
        int w, lat;
        issue(op, a, b, e, t, 1, w);
        lat = 1;
        while (!bus.o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({t, "_lat"}, lat, exp_lat);
    endtask

    task automatic drain();
        int n = 0;
        while (vq.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", vq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1;
        bus.i_valid = 0; bus.i_ready = 1; bus.i_flush = 0;
        bus.i_opt = 0; bus.i_src1 = 0; bus.i_src2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_res", bus.o_res, 0);
        chk("rst_zero", bus.o_zero, 1);
        chk("rst_busy", bus.o_busy, 0);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        // back-to-back single-cycle ops, one per cycle
        issue(ADD, 5, 7, 12, "add", 1, w);                         chk("add_wait", w, 0);
        issue(SUB, 3, 5, 32'hFFFF_FFFE, "sub", 1, w);              chk("sub_wait", w, 0);
        issue(SRA, 32'h8000_0000, 4, 32'hF800_0000, "sra", 1, w);  chk("sra_wait", w, 0);
        issue(SLL, 1, 33, 2, "sll_wrap", 1, w);
        issue(SRL, 32'h8000_0000, 31, 1, "srl", 1, w);
        issue(SLT, 32'hFFFF_FFFF, 1, 1, "slt", 1, w);
        issue(SLTU, 32'hFFFF_FFFF, 1, 0, "sltu", 1, w);
        issue(XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor", 1, w);
        issue(BLT, 32'hFFFF_FFFF, 1, 1, "blt", 1, w);
        issue(BLTU, 32'hFFFF_FFFF, 1, 0, "bltu", 1, w);
        issue(BGE, 5, 5, 1, "bge", 1, w);
        issue(BNE, 7, 7, 0, "bne", 1, w);
        issue(BEQ, 7, 7, 1, "beq", 1, w);
        issue(BGEU, 1, 32'hFFFF_FFFF, 0, "bgeu", 1, w);
        drain();

        issue_lat(25, 3, 4, 0, "illegal", 1);
        issue_lat(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh", ML);
        issue_lat(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", ML);
        issue_lat(MUL, 32'hFFFF_FFFD, 7, 32'hFFFF_FFEB, "mul", ML);
        issue_lat(MULHSU, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, "mulhsu", ML);
        issue_lat(DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, "div", 33);
        issue_lat(REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, "rem", 33);
        issue_lat(DIVU, 7, 0, 32'hFFFF_FFFF, "divu_zero", 1);
        issue_lat(REMU, 9, 0, 9, "remu_zero", 1);
        issue_lat(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf", 1);
        issue_lat(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1);
        drain();

        // backpressure: result held, new request ignored
        bus.i_ready = 0;
        issue_lat(DIVU, 100, 7, 14, "divu_bp", 33);
        bus.i_valid = 1; bus.i_opt = ADD; bus.i_src1 = 1; bus.i_src2 = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res", bus.o_res, 14);
            chk("bp_ready", bus.o_ready, 0);
            chk("bp_valid", bus.o_valid, 1);
        end
        @(posedge clk); #1;
        bus.i_valid = 0; bus.i_ready = 1;
        @(posedge clk); #1;
        drain();

        // flush mid-iteration, with a simultaneous request that must be dropped
        issue(DIV, 32'hFFFF_FFF9, 2, 0, "div_flush", 0, w);
        repeat (9) @(posedge clk);
        #1;
        bus.i_flush = 1; bus.i_valid = 1; bus.i_opt = ADD; bus.i_src1 = 1; bus.i_src2 = 1;
        @(negedge clk);
        chk("flush_busy_pre", bus.o_busy, 1);
        chk("flush_ready", bus.o_ready, 0);
        @(posedge clk); #1;
        bus.i_flush = 0; bus.i_valid = 0;
        chk("flush_busy", bus.o_busy, 0);
        chk("flush_valid", bus.o_valid, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_quiet", bus.o_valid, 0);

        // asynchronous reset mid-iteration
        issue(DIV, 32'hFFFF_FFF9, 2, 0, "div_rst", 0, w);
        repeat (9) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_busy", bus.o_busy, 0);
        chk("arst_valid", bus.o_valid, 0);
        chk("arst_res", bus.o_res, 0);
        chk("arst_zero", bus.o_zero, 1);
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        issue_lat(ADD, 1, 1, 2, "add_after_rst", 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_23060124_exu_mdu.md
Name: ysyx_23060124_exu_mdu

Overview:
- Next-generation execute unit: handshaked, parametrised-width ALU plus iterative RV32M/RV64M multiply/divide unit and branch comparator.
- Sits between IDU and LSU/WBU; accepts one operation per valid/ready transfer and returns a registered result.
- Single-cycle ops complete in 1 cycle; MUL/DIV ops iterate over multiple cycles.
- Load/store address generation is an ADD op; memory access stays in the LSU.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- OPW, 5, opcode width.
- CNTW, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  operation presented
- o_ready  output  1  unit can accept an operation this cycle
- i_opt  input  OPW  opcode
- i_src1  input  XLEN  operand 1 (reg or PC, already muxed upstream)
- i_src2  input  XLEN  operand 2 (reg, imm, CSR or 4, already muxed upstream)
- i_flush  input  1  abort in-flight op (branch mispredict/trap)
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_res  output  XLEN  result
- o_zero  output  1  o_res == 0
- o_busy  output  1  MUL/DIV iteration in progress

Behaviour:
- Opcodes:
  - ALU: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - MDU: 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - Branch: 18 BEQ, 19 BNE, 20 BLT, 21 BGE, 22 BLTU, 23 BGEU; result is 1 if taken, else 0.
  - 24-31 illegal: result 0, latency 1.
- Shift amount: i_src2[log2(XLEN)-1:0].
- Signed compares use a true signed compare, not the subtract carry.
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
  - Reset values: o_valid=0, o_res=0, o_busy=0, counter=0.
  - o_zero is always derived from o_res, so it resets to 1.
- o_ready = (state==IDLE) | (state==DONE & i_ready). This allows back-to-back single-cycle ops at 1 op/cycle.
- Transfer in: i_valid & o_ready.
  - ALU, branch or illegal op: result registered; state -> DONE next cycle (latency 1).
  - MDU op: operands latched, magnitudes taken for signed variants, counter=XLEN; state -> BUSY.
- BUSY:
  - One shift-add (MUL*) or restoring shift-subtract (DIV*/REM*) step per cycle; counter decrements.
  - On the cycle counter reaches 0, sign correction is applied and the result registered; state -> DONE.
  - MDU latency from accept to o_valid: XLEN+1 cycles.
- DONE: o_valid=1; o_res is held stable until i_ready.
  - i_ready without a new transfer -> IDLE.
  - i_ready with a new transfer -> new op is processed per the IDLE rules.
- Divide special cases, resolved at accept, latency 1, no BUSY:
  - divisor 0: DIV/DIVU quotient = all ones; REM/REMU result = i_src1.
  - signed overflow (i_src1 = 1<<(XLEN-1), i_src2 = all ones): DIV result = i_src1; REM result = 0.
- MULH/MULHSU/MULHU return the upper XLEN bits of the 2*XLEN product; MUL returns the lower XLEN bits.
- i_flush:
  - Any state -> IDLE next edge; o_valid=0; counter cleared.
  - Flush dominates a simultaneous i_valid (op dropped, o_ready is 0 that cycle).
- i_rst asserted mid-iteration: immediate return to reset values, no partial result visible.
- o_busy = (state==BUSY).
- Inputs may change freely while o_ready=0; operands are latched only on transfer.

Optional Feature:
- Macro: YSYX_23060124_EXU_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a combinational XLEN x XLEN multiplier with latency 1 and never enter BUSY. DIV/REM stay iterative.
- Undefined: all MDU ops use the iterative path, latency XLEN+1.

Test Plan:
- Reset/ALU throughput: hold i_rst high, check o_valid=0 and o_res=0. Then issue ADD 5+7, SUB 3-5, SRA 0x80000000>>4 back-to-back with i_ready=1 -> o_res = 12, 0xFFFFFFFE, 0xF8000000 on 3 consecutive cycles, o_ready stays 1.
- Branch: BLT(-1,1) -> 1; BLTU(0xFFFFFFFF,1) -> 0; BGE(5,5) -> 1; BNE(7,7) -> 0 with o_zero=1.
- Multiply (XLEN=32): MULH(0xFFFFFFFF,0xFFFFFFFF) -> 0; MULHU same operands -> 0xFFFFFFFE; MUL(-3,7) -> 0xFFFFFFEB. o_valid asserts 33 cycles after accept (1 cycle with FAST_MUL_EN).
- Divide: DIV(-7,2) -> 0xFFFFFFFD; REM(-7,2) -> 0xFFFFFFFF; DIVU(7,0) -> 0xFFFFFFFF at latency 1; REM(0x80000000,0xFFFFFFFF) -> 0.
- Backpressure: complete DIVU(100,7) with i_ready=0 for 5 cycles -> o_res=14 held stable, o_ready=0, new i_valid ignored until i_ready.
- Abort: start DIV, assert i_flush at iteration 10 -> no o_valid, IDLE next cycle. Repeat with i_rst pulse mid-iteration -> outputs return to reset values asynchronously. Next ADD 1+1 -> 2.
